// File: rtl/pa_out_fifo.sv
// pa_out_fifo
// ----------------------------------------------------------------------------
// Parallel-output stage. Bytes written through wr_data/wr_en are queued in a
// small circular FIFO. A drain state machine pops one byte at a time, drives
// it on pa_out and qualifies it with pa_strobe for STROBE_CYCLES clocks. With
// ACK_EN=1 it then waits (without timeout) for pa_ack before moving on. One
// strobe-low GAP cycle always separates consecutive bytes.
//
// Ports:
//   clock       single clock for all logic
//   reset       synchronous, active-high; discards queued and in-flight data
//   wr_data     byte to enqueue
//   wr_en       enqueue wr_data on this edge when not full
//   pa_out      byte driven to the port (holds last value when idle)
//   pa_strobe   high while pa_out carries a newly launched byte
//   pa_ack      consumer acknowledge, only looked at in WAIT_ACK
//   fifo_empty  FIFO holds no entries
//   fifo_full   FIFO holds DEPTH entries
//   level       current entry count
//   overflow    sticky, set by a write attempt while full
//   busy        state machine is not idle
//   isr         level interrupt: room available (!fifo_full)
// ----------------------------------------------------------------------------
module pa_out_fifo #(
    parameter int DEPTH         = 4,
    parameter int STROBE_CYCLES = 2,
    parameter int ACK_EN        = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic [7:0]               pa_out,
    output logic                     pa_strobe,
    input  logic                     pa_ack,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     isr
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int SCNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STROBE_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_ZERO = SCNT_W'(0);
    localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ZERO  = LVL_W'(0);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    // Registered state
    state_t             state_r;
    logic [7:0]         mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   count_r;
    logic [7:0]         out_r;
    logic               strobe_r;
    logic [SCNT_W-1:0]  scnt_r;
    logic               empty_r;
    logic               full_r;
    logic               ovf_r;
    logic               busy_r;
    logic               isr_r;

    // Combinational next values
    state_t             state_nxt_s;
    logic [7:0]         out_nxt_s;
    logic               strobe_nxt_s;
    logic [SCNT_W-1:0]  scnt_nxt_s;
    logic               pop_s;
    logic               push_s;
    logic               ovf_set_s;
    logic [LVL_W-1:0]   count_nxt_s;

    // Drain state machine: next state, launch data, strobe timing, pop request
    always_comb begin
        state_nxt_s  = state_r;
        out_nxt_s    = out_r;
        strobe_nxt_s = strobe_r;
        scnt_nxt_s   = scnt_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s        = 1'b1;
                    out_nxt_s    = mem_r[rd_ptr_r];
                    strobe_nxt_s = 1'b1;
                    scnt_nxt_s   = SCNT_LOAD;
                    state_nxt_s  = ST_DRIVE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (scnt_r != SCNT_ZERO) begin
                    scnt_nxt_s   = scnt_r - SCNT_ONE;
                end else begin
                    strobe_nxt_s = 1'b0;
                    if (ACK_EN != 0) begin
                        state_nxt_s = ST_WAIT_ACK;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end
            end
            ST_WAIT_ACK: begin
                strobe_nxt_s = 1'b0;
                if (pa_ack) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_GAP: begin
                strobe_nxt_s = 1'b0;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                strobe_nxt_s = 1'b0;
                state_nxt_s  = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a write is accepted only when not full at the edge,
    // independent of a pop on the same edge
    always_comb begin
        push_s      = 1'b0;
        ovf_set_s   = 1'b0;
        count_nxt_s = count_r;
        if (wr_en) begin
            if (full_r) begin
                ovf_set_s = 1'b1;
            end else begin
                push_s    = 1'b1;
            end
        end else begin
            push_s    = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + LVL_ONE;
            2'b01:   count_nxt_s = count_r - LVL_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; stale contents are harmless because reset clears pointers
    always_ff @(posedge clock) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // State, pointers, count and registered status/output flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= LVL_ZERO;
            out_r    <= 8'h00;
            strobe_r <= 1'b0;
            scnt_r   <= SCNT_ZERO;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            busy_r   <= 1'b0;
            isr_r    <= 1'b1;
        end else begin
            state_r  <= state_nxt_s;
            out_r    <= out_nxt_s;
            strobe_r <= strobe_nxt_s;
            scnt_r   <= scnt_nxt_s;
            count_r  <= count_nxt_s;
            // DEPTH is a power of two, so pointers wrap by plain overflow
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            // Flags are registered from the next count so they match level
            empty_r  <= (count_nxt_s == LVL_ZERO);
            full_r   <= (count_nxt_s == LVL_FULL);
            isr_r    <= (count_nxt_s != LVL_FULL);
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign pa_out     = out_r;
    assign pa_strobe  = strobe_r;
    assign fifo_empty = empty_r;
    assign fifo_full  = full_r;
    assign level      = count_r;
    assign overflow   = ovf_r;
    assign busy       = busy_r;
    assign isr        = isr_r;

endmodule
